uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller for the UART receiver. Holds the receiver's configuration registers (baud divisor `k`, `EIGHT`, `PEN`, `OHEL`) and detects completed frames on `RX_RDY`. It acknowledges each frame with a one-cycle `READ` pulse and stores the byte in an external dual-port RAM used as a circular buffer. It also maintains buffer pointers, occupancy, a saturating error counter and a host interrupt.

## Interface
- `ADDR_W`, default 8: RAM address width; buffer depth = 2^ADDR_W.
- `ERR_W`, default 8: error counter width.

- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `cfg_we`  in  1  config write strobe.
- `cfg_wdata`  in  8  config: [3:0] baud select, [4] EIGHT, [5] PEN, [6] OHEL, [7] DROP (discard errored bytes).
- `k`  out  19  receiver bit-time in clk cycles.
- `EIGHT`, `PEN`, `OHEL`  out  1 each  receiver frame format.
- `RX_RDY`  in  1  receiver has a byte.
- `RX_DATA`  in  8  received byte.
- `PERR`, `FERR`, `OVF`  in  1 each  receiver status for the current byte.
- `READ`  out  1  one-cycle acknowledge to the receiver.
- `mem_we`  out  1  RAM write enable.
- `mem_waddr`  out  ADDR_W  RAM write address (= wr_ptr).
- `mem_wdata`  out  8  RAM write data.
- `mem_raddr`  out  ADDR_W  RAM read address (= rd_ptr); host reads the head byte here.
- `pop`  in  1  host consumed the head byte.
- `count`  out  ADDR_W+1  buffered byte count.
- `empty`, `full`  out  1 each  derived from `count`.
- `err_cnt`  out  ERR_W  saturating error count.
- `err_clr`  in  1  clears `err_cnt` and `ovr`.
- `ovr`  out  1  sticky: a byte was dropped because the buffer was full.
- `irq`  out  1  registered, = !empty | ovr.

## Operation
- Config register: written on `cfg_we`; new `k` and format bits visible the next cycle. Writes are never blocked. Software writes config only while the line is idle.
- Reset config: select 5, EIGHT=1, PEN=0, OHEL=0, DROP=0, so `k` = 10417.
- Baud table (select -> k, for a 100 MHz clock):
  - 0 -> 333333 (300)
  - 1 -> 166667
  - 2 -> 83333
  - 3 -> 41667
  - 4 -> 20833
  - 5 -> 10417 (9600)
  - 6 -> 5208
  - 7 -> 2604
  - 8 -> 1736
  - 9 -> 868 (115200)
  - 10 -> 434
  - 11 -> 217
  - 12 -> 109
  - 13, 14, 15 -> 109
- FSM states: IDLE, CAPTURE, WRITE, WAIT.
  - IDLE: `RX_RDY`=1 -> CAPTURE.
  - CAPTURE: latch `RX_DATA`, `PERR`, `FERR`, `OVF`; `READ`=1 for this cycle only; -> WRITE.
  - WRITE: byte is bad if PERR|FERR|OVF.
    - If bad and DROP=1: no write.
    - Else if `full`: no write; set `ovr`.
    - Else: `mem_we`=1 and wr_ptr++.
    - `err_cnt`++ (saturating at all ones) if the byte is bad or was dropped for full.
    - -> WAIT.
  - WAIT: stay until `RX_RDY`=0, then -> IDLE. This prevents a double capture of the same byte.
- Pop: if `pop` and !empty, rd_ptr++. A `pop` while empty is ignored.
- Pointers wrap modulo 2^ADDR_W. `count` = pushes − pops, range 0..2^ADDR_W.
- Simultaneous push and pop: both pointers advance and `count` is unchanged.
- Full is evaluated on the registered `count`. A push in WRITE while full is dropped even if `pop` is asserted the same cycle.
- `err_clr` has priority over an increment in the same cycle.

## Timing
- Reset values:
  - state IDLE.
  - `READ`, `mem_we`, `ovr`, `irq` = 0.
  - wr_ptr, rd_ptr, `count`, `err_cnt` = 0.
  - `empty`=1, `full`=0.
  - config as listed under Operation.
- Reset mid-frame: all registers return to reset values asynchronously; `READ` drops immediately; any captured byte is lost.
- Latency, with `RX_RDY` sampled high on edge n:
  - `READ` high during cycle n+1.
  - `mem_we` high during n+2.
  - `count`/`empty` update after edge n+3.
  - `irq` follows one cycle after that.
- Minimum 4 cycles per byte when `RX_RDY` falls one cycle after `READ`. A frame at k ≥ 109 is never missed.
- `mem_waddr` and `mem_wdata` are stable in the `mem_we` cycle. `mem_raddr` changes the cycle after an accepted `pop`.

## Test plan
- Reset, then `RX_RDY` pulse with `RX_DATA`=0x93, no errors:
  - `READ` 1-cycle high at n+1.
  - `mem_we` at n+2 with addr 0, data 0x93.
  - `count`=1, `irq`=1.
- `cfg_wdata`=0x29 (select 9, PEN=1) -> next cycle `k`=868, PEN=1, EIGHT=0. Then `cfg_wdata`=0x0F -> `k`=109.
- Byte with PERR=1:
  - DROP=0: stored, `err_cnt`=1.
  - DROP=1: not stored, `count` unchanged, `err_cnt`=2.
- ADDR_W=2: push 4 bytes -> `full`=1. 5th byte dropped, `ovr`=1, `err_cnt`=1. `err_clr` -> `ovr`=0, `err_cnt`=0.
- Push during a `pop` at `count`=2 -> `count` stays 2. Wrap from address 3 -> 0 verified; `pop` while empty leaves rd_ptr unchanged.
- Assert `reset`=0 in CAPTURE cycle -> `READ`=0 at once, no `mem_we`, all outputs at reset values.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Receiver handshake and RAM write port of the UART receive controller.
// The controller takes the slave view; the receiver/RAM side takes the master view.
interface uart_rx_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              RX_RDY;
   logic [7:0]        RX_DATA;
   logic              PERR;
   logic              FERR;
   logic              OVF;
   logic              READ;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [7:0]        mem_wdata;

   modport slave (
      input  RX_RDY, RX_DATA, PERR, FERR, OVF,
      output READ, mem_we, mem_waddr, mem_wdata
   );

   modport master (
      output RX_RDY, RX_DATA, PERR, FERR, OVF,
      input  READ, mem_we, mem_waddr, mem_wdata
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: config register, frame capture FSM, circular-buffer
// pointers/occupancy, saturating error counter and host interrupt.
//
// state   | meaning
// IDLE    | waiting for RX_RDY
// CAPTURE | latch byte and status, READ high this cycle
// WRITE   | store byte in RAM or drop it, count errors
// WAIT    | wait for RX_RDY to fall so the same byte is not taken twice
module uart_rx_ctrl #(
   parameter int ADDR_W = 8,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [7:0]        cfg_wdata,
   output logic [18:0]       k,
   output logic              EIGHT,
   output logic              PEN,
   output logic              OHEL,
   uart_rx_ctrl_if.slave     rx,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic              pop,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic [ERR_W-1:0]  err_cnt,
   input  logic              err_clr,
   output logic              ovr,
   output logic              irq
);
   typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, WAIT} state_t;

   localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [7:0]      CFG_RST = 8'h15;

   state_t            state_q, state_d;
   logic [7:0]        cfg_q, cfg_d;
   logic              read_q, read_d;
   logic [7:0]        data_q, data_d;
   logic              bad_q, bad_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic              push_q, push_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              ovr_q, ovr_d;
   logic              irq_q, irq_d;

   logic in_write, drop_bad, drop_full, we, pop_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH);

   // Frame decisions are taken from the registered count, so a same-cycle pop never rescues a push.
   assign in_write  = (state_q == WRITE);
   assign drop_bad  = in_write && bad_q && cfg_q[7];
   assign drop_full = in_write && !drop_bad && full;
   assign we        = in_write && !drop_bad && !full;
   assign pop_ok    = pop && !empty;

   always_comb begin
      state_d  = state_q;
      cfg_d    = cfg_q;
      read_d   = 1'b0;
      data_d   = data_q;
      bad_d    = bad_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      push_d   = we;
      count_d  = count_q;
      err_d    = err_q;
      ovr_d    = ovr_q;
      irq_d    = !empty || ovr_q;

      if (cfg_we) cfg_d = cfg_wdata;

      case (state_q)
         IDLE: begin
            if (rx.RX_RDY) begin
               state_d = CAPTURE;
               read_d  = 1'b1;
            end
         end
         CAPTURE: begin
            data_d  = rx.RX_DATA;
            bad_d   = rx.PERR | rx.FERR | rx.OVF;
            state_d = WRITE;
         end
         WRITE:   state_d = WAIT;
         WAIT:    if (!rx.RX_RDY) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (we)     wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

      // Occupancy trails the write pointer by one cycle.
      case ({push_q, pop_ok})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase

      if (err_clr) begin
         err_d = '0;
         ovr_d = 1'b0;
      end else begin
         if (in_write && (bad_q || full) && (err_q != '1)) err_d = err_q + ERR_W'(1);
         if (drop_full) ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cfg_q    <= CFG_RST;
         read_q   <= 1'b0;
         data_q   <= '0;
         bad_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         push_q   <= 1'b0;
         count_q  <= '0;
         err_q    <= '0;
         ovr_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cfg_q    <= cfg_d;
         read_q   <= read_d;
         data_q   <= data_d;
         bad_q    <= bad_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         push_q   <= push_d;
         count_q  <= count_d;
         err_q    <= err_d;
         ovr_q    <= ovr_d;
         irq_q    <= irq_d;
      end
   end

   always_comb begin
      case (cfg_q[3:0])
         4'd0:    k = 19'd333333;
         4'd1:    k = 19'd166667;
         4'd2:    k = 19'd83333;
         4'd3:    k = 19'd41667;
         4'd4:    k = 19'd20833;
         4'd5:    k = 19'd10417;
         4'd6:    k = 19'd5208;
         4'd7:    k = 19'd2604;
         4'd8:    k = 19'd1736;
         4'd9:    k = 19'd868;
         4'd10:   k = 19'd434;
         4'd11:   k = 19'd217;
         default: k = 19'd109;
      endcase
   end

   assign EIGHT        = cfg_q[4];
   assign PEN          = cfg_q[5];
   assign OHEL         = cfg_q[6];
   assign rx.READ      = read_q;
   assign rx.mem_we    = we;
   assign rx.mem_waddr = wr_ptr_q;
   assign rx.mem_wdata = data_q;
   assign mem_raddr    = rd_ptr_q;
   assign count        = count_q;
   assign err_cnt      = err_q;
   assign ovr          = ovr_q;
   assign irq          = irq_q;
endmodule
